monitor_timer: RTL and testbench

MONITOR_TIMER -- requirements
Module: monitor_timer

---
 rtl/monitor_timer.sv | 114 +++++++++++
 tb/tb_monitor_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/monitor_timer.sv
// monitor_timer: measures the low and high phase durations of an on/off
// waveform in base_tempo units and publishes both counts on each falling edge.
module monitor_timer #(
    parameter int unsigned LARGURA = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               base_tempo,
    input  logic               entrada,
    input  logic               limpar_estouro,
    output logic [LARGURA-1:0] intervalo_medido,
    output logic [LARGURA-1:0] tempo_medido,
    output logic               valido,
    output logic               estouro
);

    typedef enum logic [1:0] {
        ESPERA,
        BAIXO,
        ALTO
    } estado_t;

    localparam logic [LARGURA-1:0] MAXV = '1;

    estado_t            r_estado;
    logic               r_e_q;
    logic [LARGURA-1:0] r_cnt_baixo;
    logic [LARGURA-1:0] r_cnt_alto;

    logic               w_subida;
    logic               w_descida;
    logic [LARGURA-1:0] w_carga;
    logic               w_sat_baixo;
    logic               w_sat_alto;
    logic               w_set_estouro;

    // Edge detection against the registered sample; a tick on an edge cycle
    // belongs to the phase being entered, so the counter is loaded with it.
    always_comb begin
        w_subida      = entrada & ~r_e_q;
        w_descida     = ~entrada & r_e_q;
        w_carga       = LARGURA'(base_tempo);
        w_sat_baixo   = (r_estado == BAIXO) && !w_subida && base_tempo && (r_cnt_baixo == MAXV);
        w_sat_alto    = (r_estado == ALTO) && !w_descida && base_tempo && (r_cnt_alto == MAXV);
        w_set_estouro = w_sat_baixo | w_sat_alto;
    end

    // Registered sample of the input waveform.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_q <= 1'b0;
        end else begin
            r_e_q <= entrada;
        end
    end

    // Phase state machine: counts units per phase and publishes on falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado         <= ESPERA;
            r_cnt_baixo      <= '0;
            r_cnt_alto       <= '0;
            intervalo_medido <= '0;
            tempo_medido     <= '0;
            valido           <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (r_estado)
                ESPERA: begin
                    if (w_descida) begin
                        r_estado    <= BAIXO;
                        r_cnt_baixo <= w_carga;
                        r_cnt_alto  <= '0;
                    end
                end
                BAIXO: begin
                    if (w_subida) begin
                        r_estado   <= ALTO;
                        r_cnt_alto <= w_carga;
                    end else if (base_tempo && (r_cnt_baixo != MAXV)) begin
                        r_cnt_baixo <= r_cnt_baixo + 1'b1;
                    end
                end
                ALTO: begin
                    if (w_descida) begin
                        intervalo_medido <= r_cnt_baixo;
                        tempo_medido     <= r_cnt_alto;
                        valido           <= 1'b1;
                        r_estado         <= BAIXO;
                        r_cnt_baixo      <= w_carga;
                        r_cnt_alto       <= '0;
                    end else if (base_tempo && (r_cnt_alto != MAXV)) begin
                        r_cnt_alto <= r_cnt_alto + 1'b1;
                    end
                end
                default: begin
                    r_estado <= ESPERA;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new saturation in the clearing cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estouro <= 1'b0;
        end else if (w_set_estouro) begin
            estouro <= 1'b1;
        end else if (limpar_estouro) begin
            estouro <= 1'b0;
        end
    end

endmodule

// File: tb/tb_monitor_timer.sv
// Directed testbench for monitor_timer with hand-computed expectations.
module tb_monitor_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       base_tempo = 1'b0;
    logic       entrada = 1'b0;
    logic       limpar_estouro = 1'b0;
    logic [4:0] intervalo_medido;
    logic [4:0] tempo_medido;
    logic       valido;
    logic       estouro;

    int n_checks = 0;
    int n_pass   = 0;
    int npulse   = 0;

    monitor_timer #(.LARGURA(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .base_tempo       (base_tempo),
        .entrada          (entrada),
        .limpar_estouro   (limpar_estouro),
        .intervalo_medido (intervalo_medido),
        .tempo_medido     (tempo_medido),
        .valido           (valido),
        .estouro          (estouro)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic lvl, input logic tick);
        entrada    = lvl;
        base_tempo = tick;
        @(posedge clk);
        #1;
        if (valido) npulse++;
    endtask

    // n cycles at level lvl; tick on cycles where i % per == 0 (per 0: none).
    task automatic fase(input logic lvl, input int n, input int per);
        for (int i = 0; i < n; i++) begin
            step(lvl, (per != 0) && ((i % per) == 0));
        end
    endtask

    task automatic aplica_reset(input logic lvl);
        entrada        = lvl;
        base_tempo     = 1'b0;
        limpar_estouro = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        npulse = 0;
    endtask

    task automatic checa_publica(input string tag, input int iv, input int tm);
        verifica({tag, "_valido"}, int'(valido), 1);
        verifica({tag, "_intervalo"}, int'(intervalo_medido), iv);
        verifica({tag, "_tempo"}, int'(tempo_medido), tm);
    endtask

    initial begin
        #1;
        // Reset state
        entrada = 1'b1;
        rst     = 1'b1;
        #2;
        verifica("rst_intervalo", int'(intervalo_medido), 0);
        verifica("rst_tempo", int'(tempo_medido), 0);
        verifica("rst_valido", int'(valido), 0);
        verifica("rst_estouro", int'(estouro), 0);

        // Basic period: low 7, high 3
        aplica_reset(1'b1);
        fase(1'b1, 2, 1);
        fase(1'b0, 7, 1);
        fase(1'b1, 3, 1);
        verifica("basic_nopulse", npulse, 0);
        step(1'b0, 1'b1);
        checa_publica("basic", 7, 3);
        verifica("basic_estouro", int'(estouro), 0);
        step(1'b0, 1'b1);
        verifica("basic_valido_1cyc", int'(valido), 0);
        verifica("basic_hold", int'(intervalo_medido), 7);

        // entrada high at release: first fall only arms the machine
        aplica_reset(1'b1);
        fase(1'b1, 4, 1);
        fase(1'b0, 5, 1);
        verifica("release_nopulse", npulse, 0);
        fase(1'b1, 2, 1);
        step(1'b0, 1'b1);
        checa_publica("release", 5, 2);

        // Saturation and sticky overflow
        aplica_reset(1'b1);
        fase(1'b1, 2, 1);
        fase(1'b0, 40, 1);
        verifica("sat_estouro_set", int'(estouro), 1);
        fase(1'b1, 2, 1);
        step(1'b0, 1'b1);
        checa_publica("sat", 31, 2);
        fase(1'b0, 3, 0);
        verifica("sat_sticky", int'(estouro), 1);
        limpar_estouro = 1'b1;
        step(1'b0, 1'b0);
        limpar_estouro = 1'b0;
        verifica("sat_cleared", int'(estouro), 0);
        fase(1'b0, 30, 1);
        verifica("sat_reach_max_noset", int'(estouro), 0);
        limpar_estouro = 1'b1;
        step(1'b0, 1'b1);
        limpar_estouro = 1'b0;
        verifica("sat_set_wins", int'(estouro), 1);

        // Sparse ticks every 4th cycle, aligned with the rising edge
        aplica_reset(1'b1);
        fase(1'b1, 2, 1);
        fase(1'b0, 12, 4);
        fase(1'b1, 8, 4);
        step(1'b0, 1'b1);
        checa_publica("sparse", 3, 2);
        fase(1'b0, 3, 0);
        fase(1'b1, 3, 0);
        step(1'b0, 1'b0);
        checa_publica("zero_high", 1, 0);

        // Asynchronous reset during ALTO
        aplica_reset(1'b1);
        fase(1'b1, 2, 1);
        fase(1'b0, 3, 1);
        fase(1'b1, 2, 1);
        step(1'b0, 1'b1);
        checa_publica("pre_rst", 3, 2);
        fase(1'b0, 2, 1);
        fase(1'b1, 2, 1);
        #2;
        rst = 1'b1;
        #1;
        verifica("async_intervalo", int'(intervalo_medido), 0);
        verifica("async_tempo", int'(tempo_medido), 0);
        verifica("async_valido", int'(valido), 0);
        #2;
        rst    = 1'b0;
        npulse = 0;
        fase(1'b1, 1, 1);
        step(1'b0, 1'b1);
        verifica("async_no_valido", int'(valido), 0);
        fase(1'b0, 3, 1);
        fase(1'b1, 5, 1);
        verifica("async_nopulse", npulse, 0);
        step(1'b0, 1'b1);
        checa_publica("async_next", 4, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
